ret_addr_stack: RTL and testbench
=================================

Name: ret_addr_stack

Overview:
- Hardware return-address stack for the VLIW instruction-fetch stage.
- Fetch pushes the sequential next PC when it sees a call/link jump, and pops when it sees a return.
- The current top entry is presented combinationally on ra, so fetch can redirect on a return in the same cycle.
- Circular LIFO with a fixed depth; overflow silently overwrites the oldest entry.

Parameters:
- AW, 14, width of a stored instruction address (matches the 14-bit instruction-memory index).
- DEPTH, 16, number of entries; must be a power of two ≥ 2.
- PW, $clog2(DEPTH), stack-pointer width (derived, not overridden).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- stall  input  1  1 = hold all state; push/pop ignored this cycle.
- npc  input  AW  address to push (fetch's current PC register, i.e. call address + 1).
- push  input  1  push npc this cycle.
- pop  input  1  pop top entry this cycle.
- ra  output  AW  current top-of-stack value, combinational from state.
- empty  output  AW-independent 1  only present when RASTACK_GUARD_EN is defined (see Optional Feature).

Behaviour:
- State:
  - entry array mem[0..DEPTH-1] of AW bits.
  - write pointer sp (PW bits), which points at the next free slot.
  - top = sp-1 mod DEPTH.
- Reset (rst=0, asynchronous):
  - sp=0 and every entry cleared to 0, so ra=0 during and immediately after reset.
  - Reset asserted mid-operation discards all contents at once, independent of clk.
- ra = mem[top], purely combinational. It changes only after a clock edge that modifies sp or mem[top]. There is no read latency.
- On each rising edge with rst=1 and stall=0:
  - push=1, pop=0: mem[sp] <= npc; sp <= sp+1 mod DEPTH. Next-cycle ra = npc.
  - pop=1, push=0: sp <= sp-1 mod DEPTH. Entries are not cleared; next-cycle ra = previous entry below.
  - push=1, pop=1: replace the top in place, mem[top] <= npc, sp unchanged. Next-cycle ra = npc. The ra seen this cycle is the old top.
  - neither: no change.
- stall=1: no change to sp or mem regardless of push/pop; ra holds.
- Overflow: the (DEPTH+1)th consecutive push wraps sp and overwrites the oldest entry. There is no error flag.
- Underflow (without guard): pop with nothing pushed still decrements sp mod DEPTH. ra then shows the stale or zero slot at the new top.
- Widths: npc is stored unmodified; there is no arithmetic on address data.
- Single clock domain; no handshakes. Caller guarantees push/pop are only asserted for valid instructions.

Optional Feature:
- Macro RASTACK_GUARD_EN.
- Defined:
  - An occupancy counter cnt (0..DEPTH, PW+1 bits) is added, along with output empty = (cnt==0).
  - Pop (push=0) with cnt==0 is ignored: sp and cnt are unchanged, and ra is forced to 0 while empty.
  - Push at cnt==DEPTH still wraps and overwrites the oldest entry; cnt saturates at DEPTH.
  - push+pop together leaves cnt unchanged. If empty, it behaves as a plain push (cnt becomes 1).
  - Reset clears cnt.
- Not defined: no empty port and no counter; underflow wraps as described in Behaviour.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release -> ra=0. With the guard, empty=1.
- Push 0x0010, then 0x0020, then 0x0030 on consecutive cycles -> ra is 0x0010, 0x0020, 0x0030 after each edge. Then 3 pops -> ra is 0x0020, 0x0010, then 0 (the slot below the first push).
- stall=1 with push=1 and npc=0x1234 -> ra unchanged and no entry written. Drop stall, then pop -> previous top is exposed, confirming no write occurred.
- Simultaneous push=1, pop=1 with npc=0x0ABC on a stack whose top is 0x0020 -> ra=0x0ABC next cycle. A following pop -> ra shows the entry below the original 0x0020.
- Overflow: push 0x0001..0x0011 (17 values, DEPTH=16) -> 17 pops return 0x0011 down to 0x0002, then 0x0011 again (wrap).
- Async reset mid-stream: push 3 values, then assert rst between clock edges -> ra=0 immediately, without waiting for a clock edge. With the guard: a pop on empty leaves ra=0 and empty=1.

Source files
------------

// File: rtl/ret_addr_stack.sv
// Circular return-address stack for instruction fetch; top entry is visible combinationally on ra.
// Define RASTACK_GUARD_EN to add an occupancy counter, the empty output and underflow protection.
module ret_addr_stack #(
  parameter int AW = 14,
  parameter int DEPTH = 16,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic [AW-1:0] npc,
  input  logic          push,
  input  logic          pop,
`ifdef RASTACK_GUARD_EN
  output logic          empty,
`endif
  output logic [AW-1:0] ra
);

  logic [AW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_sp;
  logic [PW-1:0] w_top;
  logic [PW-1:0] w_wrAddr;
  logic          w_isEmpty;
  logic          w_wrEn;
  logic          w_replace;
  logic          w_spInc;
  logic          w_spDec;

  assign w_top = r_sp - PW'(1);

  // An empty guarded stack turns push+pop into a plain push instead of overwriting a dead slot.
  assign w_wrEn    = !stall && push;
  assign w_replace = pop && !w_isEmpty;
  assign w_wrAddr  = w_replace ? w_top : r_sp;
  assign w_spInc   = w_wrEn && !w_replace;
  assign w_spDec   = !stall && pop && !push && !w_isEmpty;

`ifdef RASTACK_GUARD_EN
  logic [PW:0] r_cnt;

  assign w_isEmpty = (r_cnt == '0);
  assign empty     = w_isEmpty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_spInc) begin
      if (r_cnt != (PW+1)'(DEPTH)) begin
        r_cnt <= r_cnt + (PW+1)'(1);
      end
    end else if (w_spDec) begin
      r_cnt <= r_cnt - (PW+1)'(1);
    end
  end
`else
  assign w_isEmpty = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sp <= '0;
    end else if (w_spInc) begin
      r_sp <= r_sp + PW'(1);
    end else if (w_spDec) begin
      r_sp <= w_top;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wrEn) begin
      r_mem[w_wrAddr] <= npc;
    end
  end

  assign ra = w_isEmpty ? '0 : r_mem[w_top];

endmodule

// File: tb/tb_ret_addr_stack.sv
// Directed bench for ret_addr_stack: a list/array model checked every cycle plus literal checkpoints.
// Build with RASTACK_GUARD_EN defined to exercise the guarded variant.
module tb_ret_addr_stack;

  localparam int AW = 14;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst;
  logic          stall;
  logic [AW-1:0] npc;
  logic          push;
  logic          pop;
  logic [AW-1:0] ra;
`ifdef RASTACK_GUARD_EN
  logic          empty;
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  int nAsserts = 0;
  int nFails = 0;

  ret_addr_stack #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .npc   (npc),
    .push  (push),
    .pop   (pop),
`ifdef RASTACK_GUARD_EN
    .empty (empty),
`endif
    .ra    (ra)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: circular slot array, integer write index and an occupancy count
  logic [AW-1:0] mMem [DEPTH];
  int mSp;
  int mCnt;

  function automatic logic [AW-1:0] modelRa();
    if (GUARD && mCnt == 0) return '0;
    return mMem[(mSp + DEPTH - 1) % DEPTH];
  endfunction

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) mMem[i] = '0;
    mSp = 0;
    mCnt = 0;
  endtask

  task automatic modelStep(input logic pu, input logic po, input logic st, input logic [AW-1:0] a);
    if (st) return;
    if (pu && po && !(GUARD && mCnt == 0)) begin
      mMem[(mSp + DEPTH - 1) % DEPTH] = a;
    end else if (pu) begin
      mMem[mSp] = a;
      mSp = (mSp + 1) % DEPTH;
      if (mCnt < DEPTH) mCnt = mCnt + 1;
    end else if (po) begin
      if (!(GUARD && mCnt == 0)) begin
        mSp = (mSp + DEPTH - 1) % DEPTH;
        if (mCnt > 0) mCnt = mCnt - 1;
      end
    end
  endtask

  always @(negedge clk) begin
    nAsserts++;
    if (ra !== modelRa()) begin
      nFails++;
      $display("[TB] FAIL model_ra t=%0t actual=%h required=%h", $time, ra, modelRa());
    end
`ifdef RASTACK_GUARD_EN
    nAsserts++;
    if (empty !== (mCnt == 0)) begin
      nFails++;
      $display("[TB] FAIL model_empty t=%0t actual=%b required=%b", $time, empty, (mCnt == 0));
    end
`endif
  end

  task automatic applyStimulus(input logic pu, input logic po, input logic st, input logic [AW-1:0] a);
    push = pu;
    pop = po;
    stall = st;
    npc = a;
    @(posedge clk);
    modelStep(pu, po, st, a);
    #1;
    push = 1'b0;
    pop = 1'b0;
    stall = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [AW-1:0] expRa);
    nAsserts++;
    if (ra !== expRa) begin
      nFails++;
      $display("[TB] FAIL %s actual=%h required=%h", name, ra, expRa);
    end
  endtask

  task automatic checkEmpty(input string name, input logic expEmpty);
`ifdef RASTACK_GUARD_EN
    nAsserts++;
    if (empty !== expEmpty) begin
      nFails++;
      $display("[TB] FAIL %s actual=%b required=%b", name, empty, expEmpty);
    end
`else
    if (expEmpty === 1'bx) $display("[TB] %s unused", name);
`endif
  endtask

  initial begin
    rst = 1'b0;
    stall = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    npc = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    checkOutput("reset_ra", 14'h0000);
    checkEmpty("reset_empty", 1'b1);

    applyStimulus(1, 0, 0, 14'h0010); checkOutput("push1", 14'h0010);
    applyStimulus(1, 0, 0, 14'h0020); checkOutput("push2", 14'h0020);
    applyStimulus(1, 0, 0, 14'h0030); checkOutput("push3", 14'h0030);
    applyStimulus(0, 1, 0, 14'h0000); checkOutput("pop1", 14'h0020);
    applyStimulus(0, 1, 0, 14'h0000); checkOutput("pop2", 14'h0010);
    applyStimulus(0, 1, 0, 14'h0000); checkOutput("pop3", 14'h0000);

    applyStimulus(1, 0, 0, 14'h0010);
    applyStimulus(1, 0, 0, 14'h0020);
    applyStimulus(1, 0, 1, 14'h1234); checkOutput("stall_hold", 14'h0020);
    applyStimulus(0, 1, 0, 14'h0000); checkOutput("stall_nowrite", 14'h0010);

    applyStimulus(1, 0, 0, 14'h0020); checkOutput("repush", 14'h0020);
    push = 1'b1;
    pop = 1'b1;
    npc = 14'h0ABC;
    #1 checkOutput("replace_old_top", 14'h0020);
    @(posedge clk);
    modelStep(1, 1, 0, 14'h0ABC);
    #1 push = 1'b0;
    pop = 1'b0;
    checkOutput("replace_new_top", 14'h0ABC);
    applyStimulus(0, 1, 0, 14'h0000); checkOutput("replace_below", 14'h0010);

    for (int i = 1; i <= DEPTH + 1; i++) applyStimulus(1, 0, 0, AW'(i));
    checkOutput("ovf_top", 14'h0011);
    for (int i = 1; i <= DEPTH; i++) begin
      applyStimulus(0, 1, 0, 14'h0000);
      if (i < DEPTH) checkOutput("ovf_pop", AW'(17 - i));
    end
`ifdef RASTACK_GUARD_EN
    checkOutput("ovf_drained", 14'h0000);
    checkEmpty("ovf_empty", 1'b1);
`else
    checkOutput("ovf_wrap", 14'h0011);
`endif
    applyStimulus(0, 1, 0, 14'h0000);

    applyStimulus(1, 0, 0, 14'h0100);
    applyStimulus(1, 0, 0, 14'h0200);
    applyStimulus(1, 0, 0, 14'h0300); checkOutput("pre_async", 14'h0300);
    #2 rst = 1'b0;
    modelReset();
    #1 checkOutput("async_reset_ra", 14'h0000);
    checkEmpty("async_reset_empty", 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    applyStimulus(0, 1, 0, 14'h0000); checkOutput("pop_on_empty", 14'h0000);
    checkEmpty("pop_on_empty_flag", 1'b1);
    applyStimulus(1, 0, 0, 14'h0055); checkOutput("push_after_reset", 14'h0055);
    checkEmpty("push_after_reset_flag", 1'b0);
    applyStimulus(1, 1, 0, 14'h0066); checkOutput("replace_after_reset", 14'h0066);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
